// File: rtl/alu_seq_pkg.sv
// -----------------------------------------------------------------------------
// alu_seq_pkg
// Shared definitions for the ALU input sequencer: the operator-step state
// encoding, the default debounce length and the state-to-LED decode.
// -----------------------------------------------------------------------------
package alu_seq_pkg;

    typedef enum logic [1:0] {
        WAIT_A  = 2'd0,
        WAIT_B  = 2'd1,
        WAIT_OP = 2'd2,
        SHOW    = 2'd3
    } state_t;

    // 20 ms at 100 MHz
    localparam int DEBOUNCE_DEFAULT = 2_000_000;

    // One-hot step indicator: [0]=WAIT_A, [1]=WAIT_B, [2]=WAIT_OP, [3]=SHOW
    function automatic logic [3:0] state_leds(input state_t s);
        logic [3:0] leds;
        case (s)
            WAIT_A:  leds = 4'b0001;
            WAIT_B:  leds = 4'b0010;
            WAIT_OP: leds = 4'b0100;
            SHOW:    leds = 4'b1000;
            default: leds = 4'b0001;
        endcase
        return leds;
    endfunction

endpackage

// File: rtl/button_conditioner.sv
// -----------------------------------------------------------------------------
// button_conditioner
// Conditions one raw push-button: 2-FF synchroniser, debounce counter and a
// single-cycle pulse on each accepted press (debounced 0->1). Releases give no
// pulse.
//
// Ports:
//   clock     in   system clock
//   reset     in   asynchronous, active-high reset
//   btn_raw   in   raw, unsynchronised button level
//   btn_level out  debounced button level
//   btn_pulse out  one-cycle pulse on the debounced rising edge
// -----------------------------------------------------------------------------
module button_conditioner #(
    parameter int DEBOUNCE_CYCLES = 2_000_000
) (
    input  logic clock,
    input  logic reset,
    input  logic btn_raw,
    output logic btn_level,
    output logic btn_pulse
);

    // Keep at least one counter bit so tiny debounce values still elaborate
    localparam int CW = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

    logic          sync1_q;
    logic          sync2_q;
    logic          level_q, level_d;
    logic          pulse_q, pulse_d;
    logic [CW-1:0] cnt_q, cnt_d;

    // Debounce: count consecutive cycles where the synchronised level
    // disagrees with the accepted level; flip after DEBOUNCE_CYCLES of them.
    always_comb begin
        cnt_d   = cnt_q;
        level_d = level_q;
        pulse_d = 1'b0;
        if (sync2_q == level_q) begin
            cnt_d = {CW{1'b0}};
        end else if (cnt_q == CNT_LAST) begin
            cnt_d   = {CW{1'b0}};
            level_d = ~level_q;
            // Pulse only on the press direction
            pulse_d = ~level_q;
        end else begin
            cnt_d = cnt_q + CW'(1);
        end
    end

    // Synchroniser, counter and debounced state registers
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            sync1_q <= 1'b0;
            sync2_q <= 1'b0;
            level_q <= 1'b0;
            pulse_q <= 1'b0;
            cnt_q   <= {CW{1'b0}};
        end else begin
            sync1_q <= btn_raw;
            sync2_q <= sync1_q;
            level_q <= level_d;
            pulse_q <= pulse_d;
            cnt_q   <= cnt_d;
        end
    end

    assign btn_level = level_q;
    assign btn_pulse = pulse_q;

endmodule

// File: rtl/alu_input_sequencer.sv
// -----------------------------------------------------------------------------
// alu_input_sequencer
// Walks the operator through operand A, operand B and the opcode using the
// switches and two buttons, producing registered load strobes and a stable
// data bus for the ALU datapath, then commits the result one cycle after the
// opcode load.
//
// Ports:
//   clock      in   system clock
//   reset      in   asynchronous, active-high reset
//   switches   in   [N] operator switches (quasi-static)
//   btn_enter  in   raw enter button
//   btn_undo   in   raw undo button
//   data_out   out  [N] registered value for datapath data_in
//   load_A     out  one-cycle strobe: latch operand A
//   load_B     out  one-cycle strobe: latch operand B
//   load_Op    out  one-cycle strobe: latch opcode (data_out[1:0])
//   updateRes  out  one-cycle strobe: commit ALU result and flags
//   step_leds  out  [4] one-hot current step
// -----------------------------------------------------------------------------
module alu_input_sequencer
    import alu_seq_pkg::*;
#(
    parameter int N               = 16,
    parameter int DEBOUNCE_CYCLES = DEBOUNCE_DEFAULT
) (
    input  logic         clock,
    input  logic         reset,
    input  logic [N-1:0] switches,
    input  logic         btn_enter,
    input  logic         btn_undo,
    output logic [N-1:0] data_out,
    output logic         load_A,
    output logic         load_B,
    output logic         load_Op,
    output logic         updateRes,
    output logic [3:0]   step_leds
);

    logic enter_pulse;
    logic undo_pulse;
    // Debounced levels are not needed by the sequencer itself
    logic enter_level_unused;
    logic undo_level_unused;

    state_t       state_q, state_d;
    logic [N-1:0] data_q, data_d;
    logic         load_a_q, load_a_d;
    logic         load_b_q, load_b_d;
    logic         load_op_q, load_op_d;
    logic         update_q, update_d;

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_enter (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (btn_enter),
        .btn_level (enter_level_unused),
        .btn_pulse (enter_pulse)
    );

    button_conditioner #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_undo (
        .clock     (clock),
        .reset     (reset),
        .btn_raw   (btn_undo),
        .btn_level (undo_level_unused),
        .btn_pulse (undo_pulse)
    );

    // Step FSM, data bus capture and strobe generation; enter has priority
    // over undo. updateRes trails load_Op by one cycle so the opcode register
    // in the datapath has settled before the result is committed.
    always_comb begin
        state_d   = state_q;
        data_d    = data_q;
        load_a_d  = 1'b0;
        load_b_d  = 1'b0;
        load_op_d = 1'b0;
        update_d  = load_op_q;
        if (enter_pulse) begin
            case (state_q)
                WAIT_A: begin
                    data_d   = switches;
                    load_a_d = 1'b1;
                    state_d  = WAIT_B;
                end
                WAIT_B: begin
                    data_d   = switches;
                    load_b_d = 1'b1;
                    state_d  = WAIT_OP;
                end
                WAIT_OP: begin
                    data_d    = switches;
                    load_op_d = 1'b1;
                    state_d   = SHOW;
                end
                SHOW: begin
                    // Back to the start; bus held so the display stays valid
                    state_d = WAIT_A;
                end
                default: begin
                    state_d = WAIT_A;
                end
            endcase
        end else if (undo_pulse) begin
            case (state_q)
                WAIT_A:  state_d = WAIT_A;
                WAIT_B:  state_d = WAIT_A;
                WAIT_OP: state_d = WAIT_B;
                SHOW:    state_d = WAIT_OP;
                default: state_d = WAIT_A;
            endcase
        end else begin
            state_d = state_q;
        end
    end

    // Sequencer registers; reset also cancels a pending updateRes
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state_q   <= WAIT_A;
            data_q    <= {N{1'b0}};
            load_a_q  <= 1'b0;
            load_b_q  <= 1'b0;
            load_op_q <= 1'b0;
            update_q  <= 1'b0;
        end else begin
            state_q   <= state_d;
            data_q    <= data_d;
            load_a_q  <= load_a_d;
            load_b_q  <= load_b_d;
            load_op_q <= load_op_d;
            update_q  <= update_d;
        end
    end

    assign data_out  = data_q;
    assign load_A    = load_a_q;
    assign load_B    = load_b_q;
    assign load_Op   = load_op_q;
    assign updateRes = update_q;
    assign step_leds = state_leds(state_q);

endmodule

// File: tb/tb_alu_input_sequencer.sv
// -----------------------------------------------------------------------------
// tb_alu_input_sequencer
// Directed bench for alu_input_sequencer with DEBOUNCE_CYCLES=4. A negedge
// monitor logs strobe counts, cycle stamps and the bus value at each strobe;
// the main sequence drives buttons and compares against hand-computed values.
// -----------------------------------------------------------------------------
module tb_alu_input_sequencer;

    localparam int N = 16;

    logic         clock;
    logic         reset;
    logic [N-1:0] switches;
    logic         btn_enter;
    logic         btn_undo;
    logic [N-1:0] data_out;
    logic         load_A;
    logic         load_B;
    logic         load_Op;
    logic         updateRes;
    logic [3:0]   step_leds;

    int n_checks = 0;
    int n_errors = 0;

    int cyc = 0;
    int n_a = 0, n_b = 0, n_op = 0, n_upd = 0;
    int t_a = 0, t_b = 0, t_op = 0, t_upd = 0;
    logic [N-1:0] d_a = '0, d_b = '0, d_op = '0;
    int n_overlap = 0, n_long = 0;
    logic [3:0] prev_str = 4'b0000;
    int t_press = 0;

    alu_input_sequencer #(.N(N), .DEBOUNCE_CYCLES(4)) dut (
        .clock     (clock),
        .reset     (reset),
        .switches  (switches),
        .btn_enter (btn_enter),
        .btn_undo  (btn_undo),
        .data_out  (data_out),
        .load_A    (load_A),
        .load_B    (load_B),
        .load_Op   (load_Op),
        .updateRes (updateRes),
        .step_leds (step_leds)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Cycle counter
    always @(posedge clock) cyc <= cyc + 1;

    // Strobe monitor, sampled away from the active edge
    always @(negedge clock) begin
        logic [3:0] str;
        str = {updateRes, load_Op, load_B, load_A};
        if ($countones(str) > 1) n_overlap <= n_overlap + 1;
        if ((str & prev_str) != 4'b0000) n_long <= n_long + 1;
        prev_str <= str;
        if (load_A)    begin n_a   <= n_a + 1;   t_a   <= cyc; d_a  <= data_out; end
        if (load_B)    begin n_b   <= n_b + 1;   t_b   <= cyc; d_b  <= data_out; end
        if (load_Op)   begin n_op  <= n_op + 1;  t_op  <= cyc; d_op <= data_out; end
        if (updateRes) begin n_upd <= n_upd + 1; t_upd <= cyc; end
    end

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clock);
        #1;
    endtask

    // Clean press: hold for 'hold' cycles, then release and let it settle
    task automatic press(input logic en, input logic un, input int hold);
        btn_enter = en;
        btn_undo  = un;
        t_press   = cyc;
        step(hold);
        btn_enter = 1'b0;
        btn_undo  = 1'b0;
        step(10);
    endtask

    function automatic int total_strobes();
        return n_a + n_b + n_op + n_upd;
    endfunction

    initial begin
        int base;
        int a_before;
        int upd_before;
        bit seen;
        logic [0:4] bounce;

        reset     = 1'b1;
        switches  = 16'h0000;
        btn_enter = 1'b0;
        btn_undo  = 1'b0;
        step(3);

        // Reset state
        check_eq("rst_leds", step_leds, 4'b0001);
        check_eq("rst_data", data_out, 16'h0000);
        check_eq("rst_strobes", {updateRes, load_Op, load_B, load_A}, 4'b0000);
        reset = 1'b0;
        step(2);

        // 1. Full sequence
        switches = 16'h0012;
        press(1'b1, 1'b0, 10);
        check_eq("seq_a_count", n_a, 1);
        check_eq("seq_a_data", d_a, 16'h0012);
        check_eq("seq_a_latency", t_a - t_press, 7);
        check_eq("seq_leds_b", step_leds, 4'b0010);
        switches = 16'h0034;
        press(1'b1, 1'b0, 10);
        check_eq("seq_b_count", n_b, 1);
        check_eq("seq_b_data", d_b, 16'h0034);
        check_eq("seq_leds_op", step_leds, 4'b0100);
        switches = 16'h0002;
        press(1'b1, 1'b0, 10);
        check_eq("seq_op_count", n_op, 1);
        check_eq("seq_op_data", d_op, 16'h0002);
        check_eq("seq_upd_count", n_upd, 1);
        check_eq("seq_upd_delay", t_upd - t_op, 1);
        check_eq("seq_leds_show", step_leds, 4'b1000);

        // 6. Wrap-around from SHOW keeps the bus
        base = total_strobes();
        switches = 16'hFFFF;
        press(1'b1, 1'b0, 10);
        check_eq("wrap_no_strobe", total_strobes(), base);
        check_eq("wrap_leds", step_leds, 4'b0001);
        check_eq("wrap_data_held", data_out, 16'h0002);
        press(1'b1, 1'b0, 10);
        check_eq("wrap_a_count", n_a, 2);
        check_eq("wrap_a_data", d_a, 16'hFFFF);
        check_eq("wrap_leds_b", step_leds, 4'b0010);

        // 4. Simultaneous enter and undo in WAIT_B
        base = total_strobes();
        switches = 16'h0055;
        press(1'b1, 1'b1, 10);
        check_eq("simul_b_count", n_b, 2);
        check_eq("simul_b_data", d_b, 16'h0055);
        check_eq("simul_one_strobe", total_strobes(), base + 1);
        check_eq("simul_leds", step_leds, 4'b0100);

        // 3. Undo walk-back, then undo ignored in WAIT_A
        base = total_strobes();
        switches = 16'h0BAD;
        press(1'b0, 1'b1, 10);
        check_eq("undo1_leds", step_leds, 4'b0010);
        press(1'b0, 1'b1, 10);
        check_eq("undo2_leds", step_leds, 4'b0001);
        press(1'b0, 1'b1, 10);
        check_eq("undo3_leds", step_leds, 4'b0001);
        check_eq("undo_no_strobe", total_strobes(), base);
        check_eq("undo_data_held", data_out, 16'h0055);

        // 2. Bounce then stable high
        a_before = n_a;
        switches = 16'h0077;
        bounce = 5'b10110;
        for (int i = 0; i < 5; i++) begin
            btn_enter = bounce[i];
            step(1);
        end
        check_eq("bounce_quiet", n_a, a_before);
        btn_enter = 1'b1;
        t_press = cyc;
        step(8);
        btn_enter = 1'b0;
        step(10);
        check_eq("bounce_a_count", n_a, a_before + 1);
        check_eq("bounce_latency", t_a - t_press, 7);
        check_eq("bounce_data", d_a, 16'h0077);

        // 5. Reset asynchronously while load_Op is high
        switches = 16'h0009;
        press(1'b1, 1'b0, 10);
        check_eq("pre_rst_leds", step_leds, 4'b0100);
        upd_before = n_upd;
        switches = 16'h0003;
        btn_enter = 1'b1;
        seen = 1'b0;
        for (int i = 0; i < 20 && !seen; i++) begin
            step(1);
            if (load_Op) seen = 1'b1;
        end
        check_eq("op_seen", seen, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_eq("async_strobes", {updateRes, load_Op, load_B, load_A}, 4'b0000);
        check_eq("async_data", data_out, 16'h0000);
        check_eq("async_leds", step_leds, 4'b0001);
        btn_enter = 1'b0;
        step(3);
        reset = 1'b0;
        step(10);
        check_eq("rst_no_update", n_upd, upd_before);
        check_eq("post_rst_leds", step_leds, 4'b0001);
        check_eq("post_rst_data", data_out, 16'h0000);

        // Strobe hygiene over the whole run
        check_eq("strobe_overlap", n_overlap, 0);
        check_eq("strobe_width", n_long, 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule

// File: doc/alu_input_sequencer.md
Name: alu_input_sequencer

Overview:
Front-end controller that turns operator switches and two push-buttons into the load strobes and data bus consumed by the ALU register/display datapath. It walks the operator through entering operand A, operand B and the 2-bit opcode, then commits the ALU result. It drives data_in, load_A, load_B, load_Op and updateRes of the ALU datapath, and drives status LEDs showing the current step.

Parameters:
N, 16, width of switch input and data_out bus
DEBOUNCE_CYCLES, 2_000_000, consecutive stable clock cycles required to accept a button level change (20 ms at 100 MHz)

Ports:
clock  input  1  system clock
reset  input  1  asynchronous, active-high reset
switches  input  N  raw operator switches, sampled unsynchronised (quasi-static)
btn_enter  input  1  raw push-button: accept the value for the current step
btn_undo  input  1  raw push-button: go back one step
data_out  output  N  registered value presented to the datapath data_in
load_A  output  1  one-cycle strobe: latch operand A
load_B  output  1  one-cycle strobe: latch operand B
load_Op  output  1  one-cycle strobe: latch opcode (datapath uses data_out[1:0])
updateRes  output  1  one-cycle strobe: commit ALU result and flags
step_leds  output  4  one-hot current state: [0]=WAIT_A, [1]=WAIT_B, [2]=WAIT_OP, [3]=SHOW

Behaviour:
- Reset (asynchronous, active-high): state=WAIT_A; data_out=0; all strobes=0; step_leds=4'b0001; synchronisers, debounce counters and debounced levels cleared to 0.
- Button conditioning, per button:
  - 2-FF synchroniser.
  - Debounce counter, cleared whenever the synchronised level equals the debounced level.
  - When the two levels differ, the counter increments each cycle. The debounced level flips when the counter reaches DEBOUNCE_CYCLES-1, i.e. after DEBOUNCE_CYCLES consecutive differing cycles.
  - A single-cycle press pulse is emitted on the cycle the debounced level goes 0->1. Release produces no pulse.
  - Counter width is $clog2(DEBOUNCE_CYCLES). A glitch shorter than DEBOUNCE_CYCLES produces no pulse.
- FSM states: WAIT_A -> WAIT_B -> WAIT_OP -> SHOW -> WAIT_A.
- On an enter pulse (cycle T):
  - data_out <= switches, registered at the T edge, visible in T+1.
  - The strobe for the current state is asserted in T+1 only: WAIT_A->load_A, WAIT_B->load_B, WAIT_OP->load_Op.
  - State advances at the same edge.
  - From WAIT_OP: load_Op in T+1, updateRes in T+2 (opcode register settled), state=SHOW from T+1.
  - In SHOW, an enter pulse returns to WAIT_A with no strobe; data_out is unchanged.
- On an undo pulse: state steps back one with no strobe and data_out unchanged. WAIT_B->WAIT_A, WAIT_OP->WAIT_B, SHOW->WAIT_OP. In WAIT_A, undo is ignored.
- Simultaneous enter and undo pulses: enter wins, undo is dropped.
- Strobes are mutually exclusive and never asserted for more than one cycle.
- data_out changes only on an enter-pulse edge; it holds between strobes so the datapath sees a stable bus.
- Reset asserted mid-sequence, including the cycle between load_Op and updateRes: the pending updateRes is cancelled, and everything returns to reset values.
- step_leds is a direct decode of the state register (no extra latency).

Decomposition:
- Shared package alu_seq_pkg:
  - typedef enum logic [1:0] state_t {WAIT_A, WAIT_B, WAIT_OP, SHOW};
  - localparam DEBOUNCE_DEFAULT = 2_000_000.
- Sub-module button_conditioner (synchroniser + debounce + rising-edge pulse), parameter DEBOUNCE_CYCLES, ports clock, reset, btn_raw, btn_level, btn_pulse. Instantiated twice.
- FSM, data_out register and strobe generation live in the top module.

Test Plan (benches use DEBOUNCE_CYCLES=4):
1. Full sequence: a clean enter press is held ≥10 cycles per step, with switches=16'h0012, then 16'h0034, then 16'h0002.
   -> load_A with data_out=0012, then load_B with data_out=0034, then load_Op with data_out=0002.
   -> updateRes exactly 1 cycle after load_Op; step_leds ends at 4'b1000.
   -> Each strobe is high for 1 cycle.
2. Bounce: btn_enter toggles 1,0,1,1,0 at 1-cycle spacing, then is held high for 8 cycles.
   -> Exactly one load_A pulse, asserted 2 (sync) + 4 (debounce) + 1 (strobe register) cycles after the stable-high start; no pulse during bouncing.
3. Undo: from WAIT_OP, an undo press gives step_leds=0010 with no strobe. A second undo gives 0001. A further undo in WAIT_A gives no change and no strobe.
4. Simultaneous: enter and undo rise on the same cycle in WAIT_B.
   -> load_B asserted, state=WAIT_OP, undo ignored.
5. Reset mid-operation: reset is asserted asynchronously in the cycle load_Op is high.
   -> No updateRes follows; data_out=0; step_leds=0001; strobes=0 immediately, without waiting for a clock edge.
6. Wrap-around: in SHOW, an enter press with switches=16'hFFFF.
   -> Returns to WAIT_A, no strobe, data_out retains 0002. The next enter press loads A=FFFF.
